occupancy_grid_updater: RTL and testbench
=========================================

# occupancy_grid_updater

Parametrised occupancy-grid store with saturating log-odds style read-modify-write updates, a hardware clear sweep and an independent query port. Sits between the ray-tracing stage, which issues per-cell free/occupied updates, and the scan-matcher, which reads cell values. It generalises the fixed 32x16, 8-bit, wrap-around grid datapath: grid dimensions, cell width, step sizes and clear value are parameters, and arithmetic saturates instead of wrapping. It adds a ready/valid handshake and a query port.

## Interface
- X_BITS, 5, x index width; grid width = 2^X_BITS
- Y_BITS, 4, y index width; grid height = 2^Y_BITS
- CELL_WIDTH, 8, unsigned cell value width
- FREE_STEP, 1, decrement applied on a free observation
- OCCUPIED_STEP, 1, increment applied on an occupied observation
- CLEAR_VALUE, 0, value written by the clear sweep
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clear_start  in  1  request full-grid clear (sampled in IDLE only)
- clear_busy  out  1  high while the sweep runs
- clear_done  out  1  one-cycle pulse after the last cell is written
- update_valid  in  1  update request present
- update_ready  out  1  block accepts an update this cycle
- update_x  in  X_BITS  cell x index
- update_y  in  Y_BITS  cell y index
- update_free  in  1  1 = free (decrement), 0 = occupied (increment)
- update_done  out  1  one-cycle pulse in the cycle the new value is written
- update_value  out  CELL_WIDTH  value written; meaningful only when update_done = 1
- query_x  in  X_BITS  query x index
- query_y  in  Y_BITS  query y index
- query_data  out  CELL_WIDTH  cell value at the query address sampled on the previous edge

## Operation
- Address = {y, x}, row-major. Depth = 2^(X_BITS+Y_BITS).
- Storage is a dual-port RAM:
  - Port A serves internal read/write and has a registered read.
  - Port B is the read-only query port and has a registered read.
- FSM states are IDLE, READ, WRITE and CLEAR.
- IDLE:
  - update_ready = !clear_start.
  - If clear_start = 1, the block zeroes the sweep counter and goes to CLEAR. Clear has priority over a simultaneous update_valid; that update is not accepted.
  - Otherwise, on update_valid && update_ready, the block latches x, y and free, then goes to READ.
- READ: port A reads the latched address. Next state is WRITE.
- WRITE:
  - On a free observation: new = old - FREE_STEP, floored at 0.
  - On an occupied observation: new = old + OCCUPIED_STEP, capped at 2^CELL_WIDTH-1.
  - Compute in CELL_WIDTH+1 bits before clamping.
  - The block writes new, drives update_done = 1 and update_value = new, then returns to IDLE.
- CLEAR:
  - Writes CLEAR_VALUE at the counter address, one cell per cycle, incrementing the counter.
  - On the last address (all ones), it pulses clear_done in that same cycle and goes to IDLE.
  - clear_busy = 1 throughout CLEAR; update_ready = 0.
  - clear_start is ignored outside IDLE.
- Query port:
  - Always active.
  - On a read-during-write to the same address, it returns the old value.
- Reset:
  - FSM goes to IDLE; counter and latches clear.
  - Reset values: clear_busy = 0, clear_done = 0, update_done = 0, update_value = 0, query_data = 0.
  - update_ready = 1 when reset_n is high, clear_start is low and the FSM is in IDLE.
  - RAM contents are not reset. Software issues a clear after reset.
  - Reset mid-sweep or mid-update abandons the operation. The partially cleared grid or the unwritten cell is left as-is.

## Timing
- An update is accepted at edge T. From that edge:
  - T+1: READ.
  - T+2: WRITE, with update_done high.
  - T+3: update_ready high again.
- Throughput is one update per 3 cycles. There is no same-cell hazard, because updates never overlap.
- Clear started at edge T:
  - clear_busy is high for exactly 2^(X_BITS+Y_BITS) cycles.
  - clear_done is high in the final one of those cycles.
  - update_ready returns the cycle after.
- query_data latency is 1 cycle from query_x/query_y.

## Test plan
- Reset, clear, then query all cells -> clear_busy high 512 cycles (default parameters), one clear_done, every query_data = 0.
- Occupied update at (3,2) three times -> update_value 1, 2, 3. update_ready low 2 cycles after each accept. Query (3,2) = 3.
- Free update on a 0 cell -> update_value = 0 (floor). 256 occupied updates on one cell -> final value 255, no wrap.
- clear_start and update_valid asserted together in IDLE -> update not accepted, sweep runs. The held update is accepted the cycle after clear_done.
- Query (3,2) in the same cycle as the WRITE to (3,2) changing 3 -> 4 -> query_data = 3 next cycle, 4 on a repeat query.
- reset_n pulsed low at sweep cycle 100 -> outputs at reset values immediately. FSM in IDLE after release. Cells 0..99 = CLEAR_VALUE.

Source files
------------

// File: rtl/occupancy_grid_updater.sv
// Occupancy-grid store: saturating read-modify-write cell updates, full-grid clear sweep, independent query port.
// Latency: update accepted at edge T is written at edge T+2 (update_done in that cycle); query_data 1 cycle; clear 2^(X_BITS+Y_BITS) cycles.
// Backpressure: update_ready is low while an update or clear is in flight, and in IDLE whenever clear_start is high (clear wins).
//
// Ports:
//   clock, reset_n                      rising-edge clock, async active-low reset
//   clear_start / clear_busy / clear_done  clear sweep request, in-progress flag, last-cell pulse
//   update_valid / update_ready         update handshake; update_x/update_y/update_free carry the request
//   update_done / update_value          pulse and value in the cycle the new cell value is written
//   query_x / query_y / query_data      read-only query port, registered read (1 cycle)
module occupancy_grid_updater #(
  parameter int X_BITS        = 5,
  parameter int Y_BITS        = 4,
  parameter int CELL_WIDTH    = 8,
  parameter int FREE_STEP     = 1,
  parameter int OCCUPIED_STEP = 1,
  parameter int CLEAR_VALUE   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  update_valid,
  output logic                  update_ready,
  input  logic [X_BITS-1:0]     update_x,
  input  logic [Y_BITS-1:0]     update_y,
  input  logic                  update_free,
  output logic                  update_done,
  output logic [CELL_WIDTH-1:0] update_value,
  input  logic [X_BITS-1:0]     query_x,
  input  logic [Y_BITS-1:0]     query_y,
  output logic [CELL_WIDTH-1:0] query_data
);

  localparam int ADDR_W = X_BITS + Y_BITS;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [CELL_WIDTH:0]   FREE_INC   = (CELL_WIDTH+1)'(FREE_STEP);
  localparam logic [CELL_WIDTH:0]   OCC_INC    = (CELL_WIDTH+1)'(OCCUPIED_STEP);
  localparam logic [CELL_WIDTH-1:0] CLEAR_CELL = CELL_WIDTH'(CLEAR_VALUE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0]     sweep_cnt;
  logic [ADDR_W-1:0]     lat_addr;
  logic                  lat_free;
  logic                  sweep_last;

  logic [CELL_WIDTH-1:0] mem [DEPTH];
  logic [CELL_WIDTH-1:0] rd_a;
  logic [ADDR_W-1:0]     addr_a;
  logic                  we_a;
  logic [CELL_WIDTH-1:0] wdata_a;

  logic [CELL_WIDTH:0]   diff;
  logic [CELL_WIDTH:0]   sum;
  logic [CELL_WIDTH-1:0] new_val;

  assign sweep_last = &sweep_cnt;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; clear_start is only looked at in IDLE and beats a simultaneous update.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_next = CLEAR;
        end else if (update_valid) begin
          state_next = READ;
        end
      end
      READ:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      CLEAR:   state_next = sweep_last ? IDLE : CLEAR;
      default: state_next = IDLE;
    endcase
  end

  // Output and RAM-control decode
  always_comb begin
    clear_busy   = 1'b0;
    clear_done   = 1'b0;
    update_done  = 1'b0;
    update_value = '0;
    update_ready = 1'b0;
    we_a         = 1'b0;
    wdata_a      = new_val;
    addr_a       = lat_addr;
    case (state)
      IDLE: begin
        update_ready = reset_n & ~clear_start;
      end
      WRITE: begin
        update_done  = 1'b1;
        update_value = new_val;
        we_a         = 1'b1;
      end
      CLEAR: begin
        clear_busy = 1'b1;
        clear_done = sweep_last;
        we_a       = 1'b1;
        wdata_a    = CLEAR_CELL;
        addr_a     = sweep_cnt;
      end
      default: ;
    endcase
  end

  // Sweep counter and latched request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sweep_cnt <= '0;
      lat_addr  <= '0;
      lat_free  <= 1'b0;
    end else begin
      if (state == IDLE && clear_start) begin
        sweep_cnt <= '0;
      end else if (state == CLEAR) begin
        sweep_cnt <= sweep_cnt + ADDR_W'(1);
      end
      if (state == IDLE && !clear_start && update_valid) begin
        lat_addr <= {update_y, update_x};
        lat_free <= update_free;
      end
    end
  end

  // Saturating update: one extra bit catches borrow (free) or carry (occupied).
  always_comb begin
    diff = {1'b0, rd_a} - FREE_INC;
    sum  = {1'b0, rd_a} + OCC_INC;
    if (lat_free) begin
      new_val = diff[CELL_WIDTH] ? '0 : diff[CELL_WIDTH-1:0];
    end else begin
      new_val = sum[CELL_WIDTH] ? '1 : sum[CELL_WIDTH-1:0];
    end
  end

  // Port A: internal read/write, registered read. Contents are never reset.
  always_ff @(posedge clock) begin
    if (we_a) begin
      mem[addr_a] <= wdata_a;
    end
    rd_a <= mem[addr_a];
  end

  // Port B: query read; a same-edge write to the same cell returns the old value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      query_data <= '0;
    end else begin
      query_data <= mem[{query_y, query_x}];
    end
  end

endmodule

// File: tb/tb_occupancy_grid_updater.sv
module tb_occupancy_grid_updater;

  localparam int DEPTH = 512;
  localparam int CMAX  = 255;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear_start = 1'b0;
  logic       update_valid = 1'b0;
  logic       update_free = 1'b0;
  logic [4:0] update_x = '0;
  logic [3:0] update_y = '0;
  logic [4:0] query_x = '0;
  logic [3:0] query_y = '0;
  logic       clear_busy, clear_done, update_ready, update_done;
  logic [7:0] update_value, query_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  occupancy_grid_updater dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear_start  (clear_start),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .update_valid (update_valid),
    .update_ready (update_ready),
    .update_x     (update_x),
    .update_y     (update_y),
    .update_free  (update_free),
    .update_done  (update_done),
    .update_value (update_value),
    .query_x      (query_x),
    .query_y      (query_y),
    .query_data   (query_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Grid contents as plain integers (-1 = never written), plus how many
  // cycles the current clear or update still has to run.
  int m_mem [DEPTH];
  int clr_left = 0;
  int upd_left = 0;
  int m_lat    = 0;
  bit m_free   = 1'b0;
  int qreg     = 0;
  int m_nq     = 0;

  function automatic int next_val(input int v, input bit fr);
    if (fr) return (v > 0) ? v - 1 : 0;
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_left = 0;
      upd_left = 0;
      m_lat    = 0;
      m_free   = 1'b0;
      qreg     = 0;
    end else begin
      m_nq = m_mem[{query_y, query_x}];
      if (clr_left > 0) begin
        m_mem[DEPTH - clr_left] = 0;
        clr_left = clr_left - 1;
      end else if (upd_left == 2) begin
        upd_left = 1;
      end else if (upd_left == 1) begin
        m_mem[m_lat] = next_val(m_mem[m_lat], m_free);
        upd_left = 0;
      end else if (clear_start) begin
        clr_left = DEPTH;
      end else if (update_valid) begin
        m_lat    = {23'd0, update_y, update_x};
        m_free   = update_free;
        upd_left = 2;
      end
      qreg = m_nq;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clock) begin
    check("clear_busy", 32'(clear_busy), 32'(clr_left > 0));
    check("clear_done", 32'(clear_done), 32'(clr_left == 1));
    check("update_done", 32'(update_done), 32'(upd_left == 1));
    if (upd_left == 1)
      check("update_value", 32'(update_value), 32'(next_val(m_mem[m_lat], m_free)));
    check("update_ready", 32'(update_ready),
          32'(reset_n && clr_left == 0 && upd_left == 0 && !clear_start));
    if (qreg >= 0)
      check("query_data", 32'(query_data), 32'(qreg));
  end

  // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
  task automatic do_update(input int x, input int y, input bit fr, output int val, output int lat);
    int n;
    update_x = x[4:0];
    update_y = y[3:0];
    update_free = fr;
    update_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!update_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (!update_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clock); #1 update_valid = 1'b0;
    val = -1;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      lat++;
      if (update_done) begin
        val = int'(update_value);
        break;
      end
    end
    if (val < 0) check("done_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic do_query(input int x, input int y, output int val);
    query_x = x[4:0];
    query_y = y[3:0];
    @(posedge clock);
    @(negedge clock);
    val = int'(query_data);
    @(posedge clock); #1;
  endtask

  int v, l, n, busy_n, done_n, done_at, udone_at, ready_at;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = -1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_cdone", 32'(clear_done), 32'd0);
    check("rst_udone", 32'(update_done), 32'd0);
    check("rst_uval", 32'(update_value), 32'd0);
    check("rst_qdata", 32'(query_data), 32'd0);
    check("rst_ready", 32'(update_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 32'(update_ready), 32'd1);
    @(posedge clock); #1;

    // Full clear, then sweep every cell on the query port
    clear_start = 1'b1;
    @(negedge clock);
    @(posedge clock); #1 clear_start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; n = 0;
    while (n < DEPTH + 20) begin
      @(negedge clock);
      if (clear_busy) busy_n++;
      if (clear_done) begin
        done_n++;
        done_at = n;
      end
      n++;
      if (!clear_busy && busy_n > 0) break;
    end
    check("clr_busy_cycles", 32'(busy_n), 32'd512);
    check("clr_done_count", 32'(done_n), 32'd1);
    check("clr_done_pos", 32'(done_at), 32'd511);
    check("clr_ready_back", 32'(update_ready), 32'd1);
    @(posedge clock); #1;
    for (int a = 0; a <= DEPTH; a++) begin
      query_x = a[4:0];
      query_y = a[8:5];
      @(negedge clock);
      if (a > 0) check("sweep_zero", 32'(query_data), 32'd0);
      @(posedge clock); #1;
    end

    // Three occupied updates at (3,2)
    for (int k = 1; k <= 3; k++) begin
      do_update(3, 2, 1'b0, v, l);
      check("occ_value", 32'(v), 32'(k));
      check("occ_latency", 32'(l), 32'd2);
    end
    do_query(3, 2, v);
    check("query_3_2", 32'(v), 32'd3);

    // Floor on a zero cell, saturation at the top
    do_update(0, 0, 1'b1, v, l);
    check("free_floor", 32'(v), 32'd0);
    for (int k = 0; k < 256; k++) begin
      do_update(31, 7, 1'b0, v, l);
      if (k == 253) check("sat_254", 32'(v), 32'd254);
      if (k == 254) check("sat_reach", 32'(v), 32'd255);
    end
    check("sat_nowrap", 32'(v), 32'd255);

    // Query of (3,2) sampled on the same edge as its 3 -> 4 write
    query_x = 5'd0; query_y = 4'd0;
    update_x = 5'd3; update_y = 4'd2; update_free = 1'b0; update_valid = 1'b1;
    @(negedge clock);
    check("rdw_ready", 32'(update_ready), 32'd1);
    @(posedge clock); #1 update_valid = 1'b0;
    @(posedge clock); #1 query_x = 5'd3; query_y = 4'd2;
    @(negedge clock);
    check("rdw_done", 32'(update_done), 32'd1);
    check("rdw_value", 32'(update_value), 32'd4);
    @(posedge clock); #1;
    @(negedge clock);
    check("rdw_old", 32'(query_data), 32'd3);
    @(posedge clock); #1;
    @(negedge clock);
    check("rdw_new", 32'(query_data), 32'd4);
    @(posedge clock); #1;

    // clear_start and update_valid together: clear wins, update held until after clear_done
    clear_start = 1'b1;
    update_valid = 1'b1; update_x = 5'd5; update_y = 4'd5; update_free = 1'b0;
    @(negedge clock);
    check("both_ready_low", 32'(update_ready), 32'd0);
    @(posedge clock); #1 clear_start = 1'b0;
    n = 0; done_at = -1; udone_at = -1; ready_at = -1; v = -1;
    while (n < DEPTH + 20 && udone_at < 0) begin
      @(negedge clock);
      if (clear_done) done_at = n;
      if (update_done) begin
        udone_at = n;
        v = int'(update_value);
      end
      if (update_ready && update_valid) begin
        ready_at = n;
        @(posedge clock); #1 update_valid = 1'b0;
      end
      n++;
    end
    check("held_clr_done", 32'(done_at), 32'd511);
    check("held_accept", 32'(ready_at), 32'd512);
    check("held_udone", 32'(udone_at), 32'd514);
    check("held_value", 32'(v), 32'd1);
    update_valid = 1'b0;
    @(posedge clock); #1;

    // Reset in the middle of a clear sweep
    do_update(3, 3, 1'b0, v, l);
    do_update(4, 3, 1'b0, v, l);
    check("pre_4_3", 32'(v), 32'd1);
    do_update(3, 2, 1'b0, v, l);
    clear_start = 1'b1;
    @(negedge clock);
    @(posedge clock); #1 clear_start = 1'b0;
    busy_n = 0; n = 0;
    while (busy_n < 100 && n < 200) begin
      @(negedge clock);
      if (clear_busy) busy_n++;
      n++;
    end
    check("mid_busy_cnt", 32'(busy_n), 32'd100);
    @(posedge clock); #1 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(clear_busy), 32'd0);
    check("mid_rst_cdone", 32'(clear_done), 32'd0);
    check("mid_rst_udone", 32'(update_done), 32'd0);
    check("mid_rst_uval", 32'(update_value), 32'd0);
    check("mid_rst_qdata", 32'(query_data), 32'd0);
    @(posedge clock);
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check("mid_rel_ready", 32'(update_ready), 32'd1);
    check("mid_rel_busy", 32'(clear_busy), 32'd0);
    @(posedge clock); #1;
    do_query(3, 2, v);
    check("part_cell67", 32'(v), 32'd0);
    do_query(3, 3, v);
    check("part_cell99", 32'(v), 32'd0);
    do_query(4, 3, v);
    check("part_cell100", 32'(v), 32'd1);
    do_query(5, 5, v);
    check("part_cell165", 32'(v), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
